// File: rtl/uart_cmd_frame_ctrl_if.sv
// rtl/uart_cmd_frame_ctrl_if.sv - receiver handshake and register-write bundle for uart_cmd_frame_ctrl
interface uart_cmd_frame_ctrl_if #(
  parameter int limit_width = 10
);
  logic [7:0]             rx_data;
  logic                   rx_rec;
  logic                   rx_clr;
  logic [limit_width-1:0] baud_limit;
  logic [7:0]             reg_addr;
  logic [31:0]            reg_data;
  logic                   reg_wr;
  logic                   frame_err;
  logic                   busy;

  // Controller side: consumes receiver bytes, drives clear, baud and register writes.
  modport master (
    input  rx_data, rx_rec,
    output rx_clr, baud_limit, reg_addr, reg_data, reg_wr, frame_err, busy
  );

  // Environment side: the receiver and register file.
  modport slave (
    output rx_data, rx_rec,
    input  rx_clr, baud_limit, reg_addr, reg_data, reg_wr, frame_err, busy
  );
endinterface

// File: rtl/uart_cmd_frame_ctrl.sv
// rtl/uart_cmd_frame_ctrl.sv - 7-byte UART command frame parser with register writes and baud reprogramming
module uart_cmd_frame_ctrl #(
  parameter int limit_width    = 10,
  parameter int default_limit  = 868,
  parameter int min_limit      = 16,
  parameter int timeout_cycles = 1_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_cmd_frame_ctrl_if.master bus
);

  localparam int tmo_width = $clog2(timeout_cycles + 1);

  typedef enum logic [1:0] {S_HDR, S_CMD, S_DATA, S_CHK} state_t;

  state_t                 state;
  state_t                 state_next;
  logic [tmo_width-1:0]   tmo_cnt;
  logic [7:0]             addr;
  logic [7:0]             chk;
  logic [31:0]            data;
  logic [1:0]             idx;
  logic                   accept;
  logic                   timeout_hit;
  logic                   chk_ok;
  logic                   baud_ok;
  logic [limit_width-1:0] baud_req;

  // A byte is taken only when the receiver flags it and our previous clear is not still pending.
  assign accept      = bus.rx_rec && !bus.rx_clr;
  // An accepted byte on the expiry edge takes priority over the timeout.
  assign timeout_hit = (state != S_HDR) && (tmo_cnt == tmo_width'(timeout_cycles)) && !accept;
  assign chk_ok      = (bus.rx_data == chk);
  assign baud_req    = data[limit_width-1:0];
  assign baud_ok     = (baud_req >= limit_width'(min_limit)) && ((data >> limit_width) == 32'd0);
  assign bus.busy    = (state != S_HDR);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_HDR;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode: advance one state per accepted byte, abandon the frame on timeout.
  always_comb begin
    state_next = state;
    if (timeout_hit) begin
      state_next = S_HDR;
    end else if (accept) begin
      case (state)
        S_HDR:   if (bus.rx_data == 8'hA5) state_next = S_CMD;
        S_CMD:   state_next = S_DATA;
        S_DATA:  if (idx == 2'd3) state_next = S_CHK;
        S_CHK:   state_next = S_HDR;
        default: state_next = S_HDR;
      endcase
    end
  end

  // Frame datapath, receiver clear, inter-byte timeout and output strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rx_clr     <= 1'b0;
      bus.reg_wr     <= 1'b0;
      bus.frame_err  <= 1'b0;
      bus.reg_addr   <= 8'd0;
      bus.reg_data   <= 32'd0;
      bus.baud_limit <= limit_width'(default_limit);
      tmo_cnt        <= '0;
      addr           <= 8'd0;
      chk            <= 8'd0;
      data           <= 32'd0;
      idx            <= 2'd0;
    end else begin
      bus.rx_clr    <= accept;
      bus.reg_wr    <= 1'b0;
      bus.frame_err <= 1'b0;

      if (accept || state == S_HDR || timeout_hit) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end

      if (timeout_hit) begin
        bus.frame_err <= 1'b1;
      end

      if (accept) begin
        case (state)
          S_CMD: begin
            addr <= bus.rx_data;
            chk  <= bus.rx_data;
            data <= 32'd0;
            idx  <= 2'd0;
          end
          S_DATA: begin
            data <= {data[23:0], bus.rx_data};
            chk  <= chk ^ bus.rx_data;
            idx  <= idx + 2'd1;
          end
          S_CHK: begin
            if (!chk_ok) begin
              bus.frame_err <= 1'b1;
            end else if (addr != 8'hFF) begin
              bus.reg_addr <= addr;
              bus.reg_data <= data;
              bus.reg_wr   <= 1'b1;
            end else if (baud_ok) begin
              bus.baud_limit <= baud_req;
            end else begin
              bus.frame_err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
